// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller and the 16-bit datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int OPC_W   = 4,
    parameter int FUNC_W  = 8,
    parameter int ALUOP_W = 7
);
    logic [OPC_W-1:0]   opcode;
    logic [FUNC_W-1:0]  func;
    logic               mem_ready;
    logic               setWindow;
    logic               jump;
    logic               mem_write;
    logic               immdSel;
    logic               memOrALU;
    logic               toWrite;
    logic [ALUOP_W-1:0] ALUop;
    logic               pc_en;
    logic               instr_done;
    logic               mem_err;
    logic               illegal;

    modport master (
        input  opcode, func, mem_ready,
        output setWindow, jump, mem_write, immdSel, memOrALU, toWrite,
               ALUop, pc_en, instr_done, mem_err, illegal
    );

    modport slave (
        output opcode, func, mem_ready,
        input  setWindow, jump, mem_write, immdSel, memOrALU, toWrite,
               ALUop, pc_en, instr_done, mem_err, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit datapath.
// Define ILLEGAL_TRAP_EN to trap undefined instructions into HALT; otherwise they run as NOP.
module multicycle_controller #(
    parameter int OPC_W       = 4,
    parameter int FUNC_W      = 8,
    parameter int ALUOP_W     = 7,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    multicycle_controller_if.master bus
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int IR_W  = OPC_W + FUNC_W;
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        K_NOP, K_LOAD, K_STORE, K_JUMP, K_BRZ, K_WND, K_ALU, K_IMM, K_ILL
    } kind_e;

    typedef struct packed {
        logic               set_window;
        logic               jump;
        logic               mem_write;
        logic               immd_sel;
        logic               mem_or_alu;
        logic               to_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               pc_en;
    } ctrl_t;

    function automatic kind_e classify(input logic [IR_W-1:0] ir);
        logic [OPC_W-1:0]  op;
        logic [FUNC_W-1:0] fn;
        kind_e             k;
        op = ir[IR_W-1 -: OPC_W];
        fn = ir[FUNC_W-1:0];
        case (op)
            4'b0000: k = K_LOAD;
            4'b0001: k = K_STORE;
            4'b0010: k = K_JUMP;
            4'b0100: k = K_BRZ;
            4'b1001: k = K_WND;
            4'b1000: begin
                if (fn == FUNC_W'(8'h80)) k = K_NOP;
                else if ($onehot(fn))     k = K_ALU;
                else                      k = K_ILL;
            end
            4'b1100, 4'b1101, 4'b1110, 4'b1111: k = K_IMM;
            default: k = K_ILL;
        endcase
        if (!TRAP_EN && k == K_ILL) k = K_NOP;
        return k;
    endfunction

    // C-type func is one-hot in datapath order; ALUop is one-hot in ALU order.
    function automatic logic [ALUOP_W-1:0] alu_sel(input logic [IR_W-1:0] ir);
        logic [FUNC_W-1:0]  fn;
        logic [ALUOP_W-1:0] sel;
        fn  = ir[FUNC_W-1:0];
        sel = '0;
        case (classify(ir))
            K_ALU:  sel = ALUOP_W'({fn[0], fn[1], fn[6], fn[5], fn[4], fn[3], fn[2]});
            K_IMM:  sel = ALUOP_W'(1) << ir[IR_W-3 -: 2];
            K_BRZ:  sel = ALUOP_W'(2);
            K_LOAD: sel = ALUOP_W'(1);  // address add stays selected through LOAD write-back
            default: sel = '0;
        endcase
        return sel;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_e st, input logic [IR_W-1:0] ir);
        ctrl_t c;
        kind_e k;
        c = '0;
        k = classify(ir);
        case (st)
            S_DECODE: c.pc_en = (k == K_NOP);
            S_EXEC: begin
                c.alu_op     = alu_sel(ir);
                c.immd_sel   = (k == K_IMM);
                c.jump       = (k == K_JUMP);
                c.set_window = (k == K_WND);
                c.pc_en      = (k == K_JUMP) || (k == K_BRZ) || (k == K_WND);
            end
            S_MEM: c.mem_write = (k == K_STORE);
            S_WB: begin
                c.to_write   = 1'b1;
                c.mem_or_alu = (k != K_LOAD);
                c.alu_op     = alu_sel(ir);
                c.immd_sel   = (k == K_IMM);
                c.pc_en      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              illegal_q, illegal_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              mem_pc_en;
    kind_e             kind;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        mem_err_d = mem_err_q;
        illegal_d = illegal_q;
        mem_pc_en = 1'b0;
        kind      = classify(ir_q);

        case (state_q)
            S_FETCH: begin
                ir_d    = {bus.opcode, bus.func};
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    K_NOP:           state_d = S_FETCH;
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_ILL: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                    default:         state_d = S_EXEC;
                endcase
            end
            S_EXEC: state_d = (kind == K_ALU || kind == K_IMM) ? S_WB : S_FETCH;
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_d   = (kind == K_STORE) ? S_FETCH : S_WB;
                    mem_pc_en = (kind == K_STORE);
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_FETCH;
                    mem_err_d = 1'b1;
                    mem_pc_en = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Outputs are registered as the decode of the state being entered.
        ctrl_d = decode_ctrl(state_d, ir_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Completion out of MEM depends on mem_ready in that same cycle.
    assign bus.pc_en      = ctrl_q.pc_en | (mem_pc_en & ~rst);
    assign bus.instr_done = bus.pc_en;
    assign bus.setWindow  = ctrl_q.set_window;
    assign bus.jump       = ctrl_q.jump;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.immdSel    = ctrl_q.immd_sel;
    assign bus.memOrALU   = ctrl_q.mem_or_alu;
    assign bus.toWrite    = ctrl_q.to_write;
    assign bus.ALUop      = ctrl_q.alu_op;
    assign bus.mem_err    = mem_err_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues hand-computed expectations,
// a negedge monitor pops one per completed instruction and compares what it observed.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] lat;
        logic [6:0] alu_c3;
        logic       chk_done_alu;
        logic [6:0] alu_done;
        logic       tw;
        logic       moa;
        logic       jmp;
        logic       sw;
        logic       imm;
        logic [7:0] mw;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [6:0] alu_c3, input logic chk,
                                input logic [6:0] alu_done, input logic tw, input logic moa,
                                input logic jmp, input logic sw, input logic imm,
                                input int mw, input logic err);
        exp_t e;
        e.lat = 8'(lat);        e.alu_c3 = alu_c3;  e.chk_done_alu = chk;
        e.alu_done = alu_done;  e.tw = tw;          e.moa = moa;
        e.jmp = jmp;            e.sw = sw;          e.imm = imm;
        e.mw = 8'(mw);          e.err = err;
        return e;
    endfunction

    function automatic logic [16:0] all_outs();
        return {bus.setWindow, bus.jump, bus.mem_write, bus.immdSel, bus.memOrALU,
                bus.toWrite, bus.ALUop, bus.pc_en, bus.instr_done, bus.mem_err, bus.illegal};
    endfunction

    // ---------------- monitor ----------------
    int         o_cyc, o_mw;
    logic [6:0] o_alu_early, o_alu_c3;
    logic       o_tw, o_moa, o_jmp, o_sw, o_imm;
    logic       err_pend = 1'b0;
    logic       err_exp;
    string      err_nm;
    exp_t       m_e;
    string      m_nm;

    task automatic clear_obs();
        o_cyc = 0; o_mw = 0; o_alu_early = '0; o_alu_c3 = '0;
        o_tw = 1'b0; o_moa = 1'b0; o_jmp = 1'b0; o_sw = 1'b0; o_imm = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            clear_obs();
            err_pend = 1'b0;
        end else begin
            if (err_pend) begin
                check({err_nm, ".mem_err"}, 32'(bus.mem_err), 32'(err_exp));
                err_pend = 1'b0;
            end
            o_cyc++;
            if (o_cyc <= 2) o_alu_early = o_alu_early | bus.ALUop;
            if (o_cyc == 3) o_alu_c3 = bus.ALUop;
            if (bus.toWrite) begin
                o_tw  = 1'b1;
                o_moa = bus.memOrALU;
            end
            o_jmp = o_jmp | bus.jump;
            o_sw  = o_sw  | bus.setWindow;
            o_imm = o_imm | bus.immdSel;
            if (bus.mem_write) o_mw++;
            if (bus.pc_en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: pc_en=1 at cycle %0d, expected no pending instruction", o_cyc);
                end else begin
                    m_e  = exp_q.pop_front();
                    m_nm = name_q.pop_front();
                    check({m_nm, ".latency"},    32'(o_cyc),       32'(m_e.lat));
                    check({m_nm, ".instr_done"}, 32'(bus.instr_done), 32'd1);
                    check({m_nm, ".alu_early"},  32'(o_alu_early), 32'd0);
                    check({m_nm, ".alu_c3"},     32'(o_alu_c3),    32'(m_e.alu_c3));
                    if (m_e.chk_done_alu)
                        check({m_nm, ".alu_done"}, 32'(bus.ALUop), 32'(m_e.alu_done));
                    check({m_nm, ".toWrite"},    32'(o_tw),        32'(m_e.tw));
                    if (m_e.tw)
                        check({m_nm, ".memOrALU"}, 32'(o_moa),     32'(m_e.moa));
                    check({m_nm, ".jump"},       32'(o_jmp),       32'(m_e.jmp));
                    check({m_nm, ".setWindow"},  32'(o_sw),        32'(m_e.sw));
                    check({m_nm, ".immdSel"},    32'(o_imm),       32'(m_e.imm));
                    check({m_nm, ".mem_write_cycles"}, 32'(o_mw),  32'(m_e.mw));
                    err_pend = 1'b1;
                    err_exp  = m_e.err;
                    err_nm   = m_nm;
                end
                clear_obs();
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called #1 after the edge that starts FETCH; returns #1 after the edge that starts the next FETCH.
    task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] fn,
                         input int ready_cyc, input exp_t e);
        int  cyc;
        bit  done;
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.opcode = op;
        bus.func   = fn;
        cyc  = 1;
        done = 1'b0;
        while (!done) begin
            bus.mem_ready = (cyc == ready_cyc);
            @(negedge clk);
            if (bus.instr_done) begin
                done = 1'b1;
            end else if (cyc >= 60) begin
                vectors++;
                errors++;
                $display("FAIL %s.completion: no instr_done after %0d cycles, expected %0d", nm, cyc, e.lat);
                exp_q.delete();
                name_q.delete();
                do_reset();
                return;
            end else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.opcode    = '0;
        bus.func      = '0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset.outputs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        //        name        op       func   rdy  lat c3          chk done        tw moa jmp sw imm mw err
        issue("add",      4'b1000, 8'h04, -1, mk(4, 7'b0000001, 1, 7'b0000001, 1, 1, 0, 0, 0, 0, 0));
        issue("load_w3",  4'b0000, 8'h00,  6, mk(7, 7'b0000000, 0, 7'b0000000, 1, 0, 0, 0, 0, 0, 0));
        issue("brz",      4'b0100, 8'h00, -1, mk(3, 7'b0000010, 1, 7'b0000010, 0, 0, 0, 0, 0, 0, 0));
        issue("jump",     4'b0010, 8'h00, -1, mk(3, 7'b0000000, 1, 7'b0000000, 0, 0, 1, 0, 0, 0, 0));
        issue("wnd",      4'b1001, 8'h00, -1, mk(3, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 1, 0, 0, 0));
        issue("nop",      4'b1000, 8'h80, -1, mk(2, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 0, 0));
        issue("addi",     4'b1100, 8'h5a, -1, mk(4, 7'b0000001, 1, 7'b0000001, 1, 1, 0, 0, 1, 0, 0));
        issue("subi",     4'b1101, 8'h01, -1, mk(4, 7'b0000010, 1, 7'b0000010, 1, 1, 0, 0, 1, 0, 0));
        issue("ori",      4'b1111, 8'h00, -1, mk(4, 7'b0001000, 1, 7'b0001000, 1, 1, 0, 0, 1, 0, 0));
        issue("moveto",   4'b1000, 8'h01, -1, mk(4, 7'b1000000, 1, 7'b1000000, 1, 1, 0, 0, 0, 0, 0));
        issue("movefrom", 4'b1000, 8'h02, -1, mk(4, 7'b0100000, 1, 7'b0100000, 1, 1, 0, 0, 0, 0, 0));
        issue("not",      4'b1000, 8'h40, -1, mk(4, 7'b0010000, 1, 7'b0010000, 1, 1, 0, 0, 0, 0, 0));
        issue("and",      4'b1000, 8'h10, -1, mk(4, 7'b0000100, 1, 7'b0000100, 1, 1, 0, 0, 0, 0, 0));
        issue("load_w0",  4'b0000, 8'h00,  3, mk(4, 7'b0000000, 0, 7'b0000000, 1, 0, 0, 0, 0, 0, 0));
        issue("store_w0", 4'b0001, 8'h00,  3, mk(3, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 1, 0));
        issue("store_to", 4'b0001, 8'h00, -1, mk(18, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 16, 1));
        issue("store_w1", 4'b0001, 8'h00,  4, mk(4, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 2, 1));
`ifndef ILLEGAL_TRAP_EN
        issue("op0011",   4'b0011, 8'h00, -1, mk(2, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 0, 1));
        issue("ctype_03", 4'b1000, 8'h03, -1, mk(2, 7'b0000000, 1, 7'b0000000, 0, 0, 0, 0, 0, 0, 1));
`endif

        // Reset held two cycles while an ADD sits in EXEC.
        bus.opcode = 4'b1000;
        bus.func   = 8'h04;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort.exec_alu", 32'(bus.ALUop), 32'h01);
        check("abort.exec_towrite", 32'(bus.toWrite), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.rst1_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort.rst2_outputs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue("add_after_rst", 4'b1000, 8'h04, -1, mk(4, 7'b0000001, 1, 7'b0000001, 1, 1, 0, 0, 0, 0, 0));

`ifdef ILLEGAL_TRAP_EN
        bus.opcode = 4'b0011;
        bus.func   = 8'h00;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt.illegal", 32'(bus.illegal), 32'd1);
            check("halt.other_outputs", 32'(all_outs() >> 1), 32'd0);
        end
        do_reset();
        @(negedge clk);
        check("halt.cleared_by_rst", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        issue("add_after_halt", 4'b1000, 8'h08, -1, mk(4, 7'b0000010, 1, 7'b0000010, 1, 1, 0, 0, 0, 0, 0));
`endif

        repeat (3) @(posedge clk);
        check("scoreboard.leftover", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
